// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared types and helpers for the NZP condition-code logic.
//   br_state_t : branch-resolution FSM state encoding
//   CC_N/Z/P   : one-hot NZP flag encodings {N,Z,P}
//   nzp_of()   : maps a writeback value's sign/zero status to an NZP code
// ---------------------------------------------------------------------------
package cc_pkg;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_WAIT = 2'd1,
        BR_RESP = 2'd2
    } br_state_t;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    // Takes status flags rather than the value itself so every producer can
    // share it regardless of its data width. Zero takes precedence over sign.
    function automatic logic [2:0] nzp_of(input logic is_neg, input logic is_zero);
        if (is_zero) begin
            return CC_Z;
        end
        if (is_neg) begin
            return CC_N;
        end
        return CC_P;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: grants the first asserted request at or after the
// rotating pointer (wrapping N-1 -> 0); the pointer moves to the slot after
// the winner whenever a grant is issued.
// Ports:
//   Clk      in   system clock
//   Reset_n  in   asynchronous active-low reset (pointer -> 0)
//   req      in   [N-1:0] request vector
//   gnt      out  [N-1:0] one-hot (or zero) grant, combinational from req
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic [N-1:0]  gnt_raw;

    // Scan from the farthest offset back to the pointer so the last hit,
    // which is kept, is the nearest requester at or after the pointer.
    always_comb begin
        gnt_raw = '0;
        win     = '0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (req[idx]) begin
                gnt_raw      = '0;
                gnt_raw[idx] = 1'b1;
                win          = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_raw) begin
            ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Outputs must read zero while reset is held, even with requests pending.
    assign gnt = Reset_n ? gnt_raw : '0;

endmodule

// File: rtl/cc_update_arbiter.sv
// ---------------------------------------------------------------------------
// cc_update_arbiter
// Owns the NZP condition-code flags, shares the CC update port between the
// ALU (0), memory load (1) and debug poke (2) writeback sources through a
// round-robin arbiter, and resolves BR nzp masks once in-flight CC writes
// have drained (or a stall limit expires).
// Ports:
//   Clk, Reset_n  clock / asynchronous active-low reset
//   wb_valid      [N_REQ]        source i has a value to set CC from
//   wb_data       [N_REQ*DATA_W] packed values, slice i at i*DATA_W
//   wb_ready      [N_REQ]        one-hot grant (combinational)
//   br_req        branch-resolution request, held until br_done
//   br_nzp        [3]  instruction n,z,p mask, captured on acceptance
//   br_done       1-cycle result strobe
//   br_taken      branch result, valid with br_done
//   br_timeout    resolution was forced by the stall limit
//   cc_out        [3]  current {N,Z,P}
// ---------------------------------------------------------------------------
module cc_update_arbiter
    import cc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_REQ     = 3,
    parameter int STALL_MAX = 15
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [N_REQ-1:0]          wb_valid,
    input  logic [N_REQ*DATA_W-1:0]   wb_data,
    output logic [N_REQ-1:0]          wb_ready,
    input  logic                      br_req,
    input  logic [2:0]                br_nzp,
    output logic                      br_done,
    output logic                      br_taken,
    output logic                      br_timeout,
    output logic [2:0]                cc_out
);

    localparam int CNT_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

    logic signed [DATA_W-1:0] wb_sel;
    logic [2:0]               cc_q;

    br_state_t                state_q, state_d;
    logic [2:0]               nzp_q, nzp_d;
    logic [CNT_W-1:0]         stall_q, stall_d, stall_inc;
    logic                     tmo_q, tmo_d;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .req     (wb_valid),
        .gnt     (wb_ready)
    );

    // Only the granted slice is looked at; others are ignored.
    always_comb begin
        wb_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (wb_ready[i]) begin
                wb_sel = wb_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cc_q <= '0;
        end else if (|wb_ready) begin
            cc_q <= nzp_of(wb_sel[DATA_W-1], wb_sel == '0);
        end
    end

    // Branch FSM: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= BR_IDLE;
            nzp_q   <= '0;
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nzp_q   <= nzp_d;
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    // Branch FSM: next state
    always_comb begin
        state_d   = state_q;
        nzp_d     = nzp_q;
        stall_d   = stall_q;
        tmo_d     = tmo_q;
        stall_inc = (stall_q == CNT_W'(STALL_MAX)) ? stall_q : stall_q + 1'b1;
        unique case (state_q)
            BR_IDLE: begin
                if (br_req) begin
                    nzp_d   = br_nzp;
                    stall_d = '0;
                    tmo_d   = 1'b0;
                    state_d = (|wb_valid) ? BR_WAIT : BR_RESP;
                end
            end
            BR_WAIT: begin
                stall_d = stall_inc;
                if (wb_valid == '0) begin
                    state_d = BR_RESP;
                end else if (stall_inc == CNT_W'(STALL_MAX)) begin
                    state_d = BR_RESP;
                    tmo_d   = 1'b1;
                end
            end
            BR_RESP: begin
                // br_req is still high here; it is not a fresh request.
                state_d = BR_IDLE;
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    // Branch FSM: outputs. Uses the registered CC, so a write granted in the
    // response cycle does not influence the result.
    always_comb begin
        br_done    = 1'b0;
        br_taken   = 1'b0;
        br_timeout = 1'b0;
        if (state_q == BR_RESP) begin
            br_done    = 1'b1;
            br_taken   = (nzp_q == 3'b111) | (|(nzp_q & cc_q));
            br_timeout = tmo_q;
        end
    end

    assign cc_out = cc_q;

endmodule

// File: tb/tb_cc_update_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cc_update_arbiter
// Directed-vector bench for cc_update_arbiter. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_cc_update_arbiter;

    localparam int DATA_W    = 16;
    localparam int N_REQ     = 3;
    localparam int STALL_MAX = 15;

    logic                    Clk = 1'b0;
    logic                    Reset_n;
    logic [N_REQ-1:0]        wb_valid;
    logic [N_REQ*DATA_W-1:0] wb_data;
    logic [N_REQ-1:0]        wb_ready;
    logic                    br_req;
    logic [2:0]              br_nzp;
    logic                    br_done;
    logic                    br_taken;
    logic                    br_timeout;
    logic [2:0]              cc_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    cc_update_arbiter #(
        .DATA_W    (DATA_W),
        .N_REQ     (N_REQ),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .br_req     (br_req),
        .br_nzp     (br_nzp),
        .br_done    (br_done),
        .br_taken   (br_taken),
        .br_timeout (br_timeout),
        .cc_out     (cc_out)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        wb_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        wb_valid = '0;
        wb_data  = '0;
        br_req   = 1'b0;
        br_nzp   = 3'b000;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] t5_vals [4];
        t5_vals[0] = 16'h0003;
        t5_vals[1] = 16'h0004;
        t5_vals[2] = 16'h0002;
        t5_vals[3] = 16'h8000;

        // Reset state
        do_reset();
        settle();
        check("rst_cc", cc_out, 3'b000);
        check("rst_ready", wb_ready, 3'b000);
        check("rst_done", br_done, 1'b0);
        check("rst_taken", br_taken, 1'b0);
        check("rst_tmo", br_timeout, 1'b0);

        // 1: ALU only, 0000 -> Z, 8001 -> N, 0005 -> P
        wb_valid = 3'b001;
        set_data(0, 16'h0000);
        settle();
        check("t1_ready0", wb_ready, 3'b001);
        tick();
        set_data(0, 16'h8001);
        settle();
        check("t1_cc_z", cc_out, 3'b010);
        check("t1_ready1", wb_ready, 3'b001);
        tick();
        set_data(0, 16'h0005);
        settle();
        check("t1_cc_n", cc_out, 3'b100);
        check("t1_ready2", wb_ready, 3'b001);
        tick();
        wb_valid = 3'b000;
        settle();
        check("t1_cc_p", cc_out, 3'b001);
        check("t1_noready", wb_ready, 3'b000);

        // 2: all three valid, pointer 0 -> grants 001,010,100
        do_reset();
        wb_valid = 3'b111;
        set_data(0, 16'h0000);
        set_data(1, 16'h8000);
        set_data(2, 16'h0007);
        settle();
        check("t2_g0", wb_ready, 3'b001);
        tick();
        settle();
        check("t2_cc0", cc_out, 3'b010);
        check("t2_g1", wb_ready, 3'b010);
        tick();
        settle();
        check("t2_cc1", cc_out, 3'b100);
        check("t2_g2", wb_ready, 3'b100);
        tick();
        // Pointer has wrapped to 0; source 0 idle so source 1 wins
        wb_valid = 3'b110;
        settle();
        check("t2_cc2", cc_out, 3'b001);
        check("t2_wrap_g1", wb_ready, 3'b010);
        tick();
        // Pointer at 2 with only 0 and 1 valid: wraps to 0
        wb_valid = 3'b011;
        settle();
        check("t2_wrap_cc", cc_out, 3'b100);
        check("t2_wrap_g0", wb_ready, 3'b001);
        tick();
        wb_valid = 3'b000;
        settle();
        check("t2_wrap_cc0", cc_out, 3'b010);

        // 3: nzp=100 after reset, no writes -> not taken
        do_reset();
        br_req = 1'b1;
        br_nzp = 3'b100;
        settle();
        check("t3_done_t", br_done, 1'b0);
        tick();
        settle();
        check("t3_done", br_done, 1'b1);
        check("t3_taken", br_taken, 1'b0);
        check("t3_tmo", br_timeout, 1'b0);
        tick();
        br_req = 1'b0;
        settle();
        check("t3_pulse", br_done, 1'b0);

        // 4: nzp=111 after reset -> taken
        do_reset();
        br_req = 1'b1;
        br_nzp = 3'b111;
        settle();
        tick();
        settle();
        check("t4_done", br_done, 1'b1);
        check("t4_taken", br_taken, 1'b1);
        tick();
        br_req = 1'b0;
        settle();
        check("t4_pulse", br_done, 1'b0);

        // 5: ALU valid 4 cycles ending negative, branch waits for the drain
        do_reset();
        br_nzp = 3'b100;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            wb_valid = (k < 4) ? 3'b001 : 3'b000;
            if (k < 4) set_data(0, t5_vals[k]);
            br_req = 1'b1;
            settle();
            check("t5_done", br_done, (k == 5));
            if (k == 5) begin
                check("t5_cc", cc_out, 3'b100);
                check("t5_taken", br_taken, 1'b1);
                check("t5_tmo", br_timeout, 1'b0);
            end
        end
        tick();
        br_req = 1'b0;
        settle();
        check("t5_pulse", br_done, 1'b0);

        // 6: valid held for 20 cycles -> forced resolution after 15 waits
        do_reset();
        wb_valid = 3'b001;
        set_data(0, 16'h0001);
        br_nzp = 3'b001;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            br_req = (k <= 16);
            settle();
            check("t6_done", br_done, (k == 16));
            if (k == 16) begin
                check("t6_tmo", br_timeout, 1'b1);
                check("t6_taken", br_taken, 1'b1);
            end
        end
        wb_valid = 3'b000;

        // 7: reset asserted while in BR_WAIT
        do_reset();
        wb_valid = 3'b001;
        set_data(0, 16'h8000);
        br_req = 1'b1;
        br_nzp = 3'b100;
        settle();
        tick();
        tick();
        settle();
        check("t7_pre_cc", cc_out, 3'b100);
        check("t7_pre_done", br_done, 1'b0);
        Reset_n = 1'b0;
        #1;
        check("t7_cc", cc_out, 3'b000);
        check("t7_ready", wb_ready, 3'b000);
        check("t7_done", br_done, 1'b0);
        check("t7_taken", br_taken, 1'b0);
        check("t7_tmo", br_timeout, 1'b0);
        tick();
        wb_valid = 3'b000;
        br_req   = 1'b0;
        Reset_n  = 1'b1;
        settle();
        check("t7_hold_done", br_done, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            check("t7_no_done", br_done, 1'b0);
        end
        // A fresh request with no writes resolves next cycle, so FSM is idle
        br_req = 1'b1;
        br_nzp = 3'b111;
        settle();
        tick();
        settle();
        check("t7_idle_done", br_done, 1'b1);
        check("t7_idle_taken", br_taken, 1'b1);
        tick();
        br_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
